box_draw_ctrl: RTL and testbench

BOX_DRAW_CTRL -- requirements
Module: box_draw_ctrl

---
 rtl/box_draw_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_box_draw_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/box_draw_ctrl.sv
// box_draw_ctrl: draws a BOX_W x BOX_H filled box or clears the whole screen,
// emitting one pixel per cycle in raster order towards a VGA adapter.
// All outputs are registered; the pixel shown in a cycle is computed one
// cycle ahead so the first pixel appears the cycle after a request is taken.
module box_draw_ctrl #(
  parameter int         BOX_W     = 4,
  parameter int         BOX_H     = 4,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic [2:0] colour_in,
  input  logic       draw_req,
  input  logic       clear_req,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DRAW_XLIM = 8'(BOX_W - 1);
  localparam logic [6:0] DRAW_YLIM = 7'(BOX_H - 1);
  localparam logic [7:0] CLR_XLIM  = 8'(SCREEN_W - 1);
  localparam logic [6:0] CLR_YLIM  = 7'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W9    = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8    = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] x_base_q, x_base_d;
  logic [6:0] y_base_q, y_base_d;
  logic [2:0] col_lat_q, col_lat_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-pixel address path
  logic [7:0] xlim_s;
  logic [6:0] ylim_s;
  logic       last_s;
  logic       clear_path_s;
  logic [7:0] off_x_s;
  logic [6:0] off_y_s;
  logic [7:0] base_x_s;
  logic [6:0] base_y_s;
  logic [8:0] sum_x_s;
  logic [7:0] sum_y_s;
  logic       in_screen_s;

  // Work out the offsets, base and screen coordinate of the next pixel to show
  always_comb begin
    clear_path_s = (state_q == S_CLEAR) || ((state_q == S_IDLE) && clear_req);
    if (state_q == S_CLEAR) begin
      xlim_s = CLR_XLIM;
      ylim_s = CLR_YLIM;
    end else begin
      xlim_s = DRAW_XLIM;
      ylim_s = DRAW_YLIM;
    end
    last_s = (cx_q == xlim_s) && (cy_q == ylim_s);

    // From IDLE the first pixel is offset (0,0); otherwise step raster order
    if (state_q == S_IDLE) begin
      off_x_s = 8'd0;
      off_y_s = 7'd0;
    end else if (cx_q == xlim_s) begin
      off_x_s = 8'd0;
      off_y_s = 7'(cy_q + 7'd1);
    end else begin
      off_x_s = 8'(cx_q + 8'd1);
      off_y_s = cy_q;
    end

    // A draw accepted in the same cycle as a load uses the freshly loaded base
    if (clear_path_s) begin
      base_x_s = 8'd0;
      base_y_s = 7'd0;
    end else if (state_q == S_IDLE) begin
      base_x_s = ld_x ? data_in : x_base_q;
      base_y_s = ld_y ? data_in[6:0] : y_base_q;
    end else begin
      base_x_s = x_base_q;
      base_y_s = y_base_q;
    end

    sum_x_s     = {1'b0, base_x_s} + {1'b0, off_x_s};
    sum_y_s     = {1'b0, base_y_s} + {1'b0, off_y_s};
    in_screen_s = (sum_x_s < SCR_W9) && (sum_y_s < SCR_H8);
  end

  // FSM next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    x_base_d  = x_base_q;
    y_base_d  = y_base_q;
    col_lat_d = col_lat_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_base_d = ld_x ? data_in : x_base_q;
        y_base_d = ld_y ? data_in[6:0] : y_base_q;
        busy_d   = 1'b0;
        if (clear_req) begin
          state_d  = S_CLEAR;
          cx_d     = 8'd0;
          cy_d     = 7'd0;
          busy_d   = 1'b1;
          plot_d   = in_screen_s;
          x_d      = sum_x_s[7:0];
          y_d      = sum_y_s[6:0];
          colour_d = BG_COLOUR;
        end else if (draw_req) begin
          state_d   = S_DRAW;
          col_lat_d = colour_in;
          cx_d      = 8'd0;
          cy_d      = 7'd0;
          busy_d    = 1'b1;
          plot_d    = in_screen_s;
          x_d       = sum_x_s[7:0];
          y_d       = sum_y_s[6:0];
          colour_d  = colour_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAW, S_CLEAR: begin
        busy_d = 1'b1;
        if (last_s) begin
          state_d = S_DONE;
          plot_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cx_d     = off_x_s;
          cy_d     = off_y_s;
          plot_d   = in_screen_s;
          x_d      = sum_x_s[7:0];
          y_d      = sum_y_s[6:0];
          colour_d = (state_q == S_CLEAR) ? BG_COLOUR : col_lat_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation at once
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_base_q  <= 8'd0;
      y_base_q  <= 7'd0;
      col_lat_q <= 3'd0;
      cx_q      <= 8'd0;
      cy_q      <= 7'd0;
      plot_q    <= 1'b0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      colour_q  <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_base_q  <= x_base_d;
      y_base_q  <= y_base_d;
      col_lat_q <= col_lat_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_box_draw_ctrl.sv
// Testbench for box_draw_ctrl: directed and randomized box draws plus a full
// clear, each compared pixel by pixel against a nested-loop reference model.
module tb_box_draw_ctrl;

  localparam int BW = 4;
  localparam int BH = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       ld_x;
  logic       ld_y;
  logic [2:0] colour_in;
  logic       draw_req;
  logic       clear_req;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference copy of the coordinate registers
  int mx_base = 0;
  int my_base = 0;

  box_draw_ctrl #(
    .BOX_W(BW), .BOX_H(BH), .SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOUR(3'b000)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .data_in  (data_in),
    .ld_x     (ld_x),
    .ld_y     (ld_y),
    .colour_in(colour_in),
    .draw_req (draw_req),
    .clear_req(clear_req),
    .plot     (plot),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .busy     (busy),
    .done     (done)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input bit dox, input bit doy, input logic [7:0] v);
    data_in = v;
    ld_x    = dox;
    ld_y    = doy;
    tick();
    ld_x    = 1'b0;
    ld_y    = 1'b0;
    if (dox) mx_base = int'(v);
    if (doy) my_base = int'(v[6:0]);
  endtask

  // Issue a draw or clear and compare every emitted pixel with the model.
  // both: raise draw_req alongside clear_req; hold: keep the request high;
  // mid: pulse draw_req and ld_x=0x10 while the operation runs.
  task automatic run_op(input bit clr, input bit both, input bit hold, input bit mid,
                        input logic [2:0] col);
    int w, h, bx, by, px, py, n;
    logic [2:0] ecol;
    bit ep;
    w    = clr ? SW : BW;
    h    = clr ? SH : BH;
    bx   = clr ? 0 : mx_base;
    by   = clr ? 0 : my_base;
    ecol = clr ? 3'b000 : col;
    colour_in = col;
    if (clr) clear_req = 1'b1;
    if (!clr || both) draw_req = 1'b1;
    tick();
    if (!hold) begin
      draw_req  = 1'b0;
      clear_req = 1'b0;
    end
    colour_in = ~col;
    n = 0;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        px = bx + xx;
        py = by + yy;
        ep = (px < SW) && (py < SH);
        chk("busy_op", 32'(busy), 32'd1);
        chk("done_op", 32'(done), 32'd0);
        chk("plot", 32'(ep), 32'(plot));
        chk("x", 32'(x), 32'(px & 255));
        chk("y", 32'(y), 32'(py & 127));
        chk("colour", 32'(colour), 32'(ecol));
        if (mid && n == 100) begin
          data_in  = 8'h10;
          ld_x     = 1'b1;
          draw_req = 1'b1;
        end
        tick();
        if (mid && n == 100) begin
          data_in  = 8'h00;
          ld_x     = 1'b0;
          draw_req = 1'b0;
        end
        n++;
      end
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("plot_done", 32'(plot), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    tick();
    chk("done_after", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("plot_after", 32'(plot), 32'd0);
  endtask

  // Directed and randomized stimulus sequence
  initial begin
    logic [7:0] rv;
    logic [2:0] rc;
    reset     = 1'b1;
    data_in   = 8'h00;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    colour_in = 3'd0;
    draw_req  = 1'b0;
    clear_req = 1'b0;
    repeat (3) tick();
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Box at (72,72) in colour 5
    load(1'b0, 1'b1, 8'h48);
    load(1'b1, 1'b0, 8'h48);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd5);

    // Box clipped at the bottom-right corner
    load(1'b1, 1'b0, 8'd158);
    load(1'b0, 1'b1, 8'd118);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd3);

    // Randomized draws, half of them biased towards the clipping edges
    for (int i = 0; i < 10; i++) begin
      rv = 8'($urandom_range(0, 255));
      if (i % 2 == 1) rv = 8'($urandom_range(150, 255));
      load(1'b1, 1'b0, rv);
      rv = 8'($urandom_range(0, 127));
      if (i % 2 == 1) rv = 8'($urandom_range(110, 127));
      load(1'b0, 1'b1, rv);
      rc = 3'($urandom_range(0, 7));
      run_op(1'b0, 1'b0, 1'b0, 1'b0, rc);
    end

    // Both coordinates loaded in the same cycle
    load(1'b1, 1'b1, 8'h37);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd6);

    // Level-held draw request restarts on the first IDLE cycle
    load(1'b1, 1'b1, 8'h20);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd2);

    // Clear wins over draw; mid-clear draw and load are dropped
    load(1'b1, 1'b0, 8'h40);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);

    // Reset at the 5th pixel of a draw
    load(1'b1, 1'b0, 8'h20);
    load(1'b0, 1'b1, 8'h05);
    colour_in = 3'd6;
    draw_req  = 1'b1;
    tick();
    draw_req = 1'b0;
    repeat (4) tick();
    chk("pre_rst_plot", 32'(plot), 32'd1);
    chk("pre_rst_x", 32'(x), 32'h20);
    chk("pre_rst_y", 32'(y), 32'h06);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (2) tick();
    reset   = 1'b0;
    mx_base = 0;
    my_base = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
